// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package nibble_serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Nibble counter width; at least one bit so WIDTH=4 (NIB=1) still has a counter.
   function automatic int nib_w(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_add_4.sv
// 4-bit ripple-carry adder: the single shared datapath adder.
module add_4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       ci_i,
   output logic [3:0] s_o,
   output logic       co_o
);

   logic [4:0] c;

   // Bit-by-bit ripple of the carry chain.
   always_comb begin
      c[0] = ci_i;
      s_o  = '0;
      for (int i = 0; i < 4; i++) begin
         s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
      co_o = c[4];
   end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed LSB-nibble-first through one add_4 over
// WIDTH/4 cycles, with valid/ready handshakes on both sides.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf,
   output logic             busy
);

   localparam int NIB   = WIDTH / 4;
   localparam int NIB_W = nib_w(NIB);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic               carry_q, carry_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic [NIB_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               co_q, co_d;
   logic               ovf_q, ovf_d;

   logic [3:0]         nib_s;
   logic               nib_co;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH-1:0]   s_ext;
   logic [WIDTH-1:0]   sum_sr_nxt;

   add_4 u_add_4 (
      .a_i  (a_sr_q[3:0]),
      .b_i  (b_sr_q[3:0]),
      .ci_i (carry_q),
      .s_o  (nib_s),
      .co_o (nib_co)
   );

   // Subtract is A + ~B + 1; the new nibble enters the top of the result shifter.
   always_comb begin
      b_eff      = op_sub ? ~b : b;
      s_ext      = '0;
      s_ext[3:0] = nib_s;
      sum_sr_nxt = (sum_sr_q >> 4) | (s_ext << (WIDTH - 4));
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      co_d     = co_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b_eff;
               carry_d = op_sub ? 1'b1 : ci;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b_eff[WIDTH-1];
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sr_d   = a_sr_q >> 4;
            b_sr_d   = b_sr_q >> 4;
            sum_sr_d = sum_sr_nxt;
            carry_d  = nib_co;
            cnt_d    = cnt_q + NIB_W'(1);
            if (cnt_q == NIB_W'(NIB - 1)) begin
               state_d = DONE;
               sum_d   = sum_sr_nxt;
               co_d    = nib_co;
               ovf_d   = (a_msb_q == b_msb_q) && (sum_sr_nxt[WIDTH-1] != a_msb_q);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         co_q     <= co_d;
         ovf_q    <= ovf_d;
      end
   end

   // Handshake flags decode registered state only.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      sum       = sum_q;
      co        = co_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16.
module tb_nibble_serial_add_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          ci = 1'b0;
   logic          op_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          co;
   logic          ovf;
   logic          busy;

   int checks = 0;
   int errors = 0;

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, check latency and result, then retire it.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tci, input logic tsub,
                         input logic [W-1:0] es, input logic eco, input logic eovf);
      int lat;
      @(negedge clk);
      a = ta; b = tb; ci = tci; op_sub = tsub; in_valid = 1'b1;
      chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta; b = ~tb; ci = ~tci; op_sub = ~tsub;
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 20);
      chk({tag, ".latency"}, lat, 32'd4);
      chk({tag, ".sum"}, {16'd0, sum}, {16'd0, es});
      chk({tag, ".co"}, {31'd0, co}, {31'd0, eco});
      chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int lat;
      // Reset state
      #12;
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.sum", {16'd0, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("carry_in", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      // Backpressure: hold DONE while new operands are offered.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; ci = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 20);
      chk("bp.latency", lat, 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = 16'h0100 + 16'(i); b = 16'h0A0A; in_valid = 1'b1;
         @(posedge clk); #1;
         chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp.sum", {16'd0, sum}, 32'h3333);
         chk("bp.co", {31'd0, co}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp.release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp.not_accepted", {31'd0, busy}, 32'd0);
      chk("bp.idle_hold_sum", {16'd0, sum}, 32'h3333);
      run_op("after_bp", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

      // Asynchronous reset two RUN cycles into an operation with a live carry.
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0001; ci = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.sum", {16'd0, sum}, 32'd0);
      chk("arst.busy", {31'd0, busy}, 32'd0);
      chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that computes a WIDTH-bit add or subtract by time-multiplexing one 4-bit ripple-carry adder (add_4) over WIDTH/4 cycles.
- Operand nibbles are fed LSB-first; carry is registered between nibbles.
- Valid/ready handshakes on both the input and output sides.
- Sits between an operand producer and a result consumer wherever area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and ≥4.
- NIB, WIDTH/4, derived localparam: number of nibble cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in; ignored when op_sub=1
- op_sub  in  1  1 = compute A−B as A+~B+1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- co  out  1  final carry-out; for subtract, 1 = no borrow
- ovf  out  1  two's-complement signed overflow
- busy  out  1  state != IDLE

Behaviour:
- Reset is decided: one clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low → state=IDLE; sum, co, ovf, out_valid, busy = 0; in_ready = 1; all internal registers cleared.
  - Applies immediately, including mid-RUN or in DONE. A partial result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge:
    - latch a into shift reg A_sr.
    - latch b_eff = op_sub ? ~b : b into B_sr.
    - carry_r = op_sub ? 1 : ci.
    - capture a[WIDTH-1] and b_eff[WIDTH-1] for overflow.
    - nib_cnt = 0 → RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add_4 gets A_sr[3:0], B_sr[3:0], carry_r.
  - On the edge:
    - add_4 S is shifted into the top nibble of sum_sr, which shifts right by 4.
    - A_sr and B_sr shift right by 4.
    - carry_r ← add_4 Co.
    - nib_cnt increments.
  - When nib_cnt==NIB−1 on an edge → DONE. Register sum=final sum_sr, co=Co of last nibble, ovf=(a_msb==beff_msb)&&(sum[WIDTH-1]!=a_msb).
- DONE:
  - out_valid=1; sum/co/ovf held stable until out_valid&&out_ready.
  - On handshake → IDLE; out_valid drops on that edge.
  - in_ready=0 throughout DONE, so in_valid is ignored.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles when out_ready is tied high. Operations never overlap.
- Input stability: a/b/ci/op_sub only need to be valid at the accepting edge.
- Outputs after handshake: sum/co/ovf keep their last values in IDLE until the next DONE; only out_valid qualifies them.
- in_ready and busy are decoded from registered state, with no combinational path from in_valid or out_ready.
- WIDTH=4 (NIB=1): RUN lasts one cycle; no special case.

Decomposition:
- Shared package: state enum {IDLE, RUN, DONE}; NIB_W = clog2(NIB) counter-width function.
- Sub-module: one instance of the existing add_4 nibble adder as the only datapath adder. No other sub-modules.
- Controller FSM, shift registers and overflow logic live in this module.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, ci=0, op_sub=0 → sum=0x5555, co=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
2. a=0xFFFF, b=0x0001, ci=0 → sum=0x0000, co=1, ovf=0; carry propagates through all 4 nibbles. a=0xFFFF, b=0x0000, ci=1 → same result.
3. a=0x7FFF, b=0x0001, ci=0 → sum=0x8000, co=0, ovf=1. op_sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, co=1, ovf=1.
4. op_sub=1, a=0x0005, b=0x0007, ci=1 (must be ignored) → sum=0xFFFE, co=0, ovf=0.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands.
   - Required: out_valid stays 1, sum/co/ovf stay stable, in_ready stays 0, new operands are not accepted.
   - Raising out_ready gives IDLE next cycle, then the next operation is accepted.
6. Reset mid-operation:
   - Assert rst_n low asynchronously (between clock edges) after 2 RUN cycles.
   - Required: outputs clear to 0 without waiting for a clock edge; busy=0 and in_ready=1 immediately.
   - After release, a=0x00FF, b=0x0001 → sum=0x0100, co=0, with no stale carry.
